// File: rtl/gpio_cfg_decoder_pkg.sv
// Shared config package: PS GPIO word layout, trigger register addresses and
// the config-write record carried from the GPIO decoder to the register file.
package gpio_cfg_decoder_pkg;

  localparam int gpio_word_width = 25;
  localparam int gpio_wclk_bit   = 24;
  localparam int gpio_data_lsb   = 16;
  localparam int gpio_data_width = 8;
  localparam int gpio_addr_lsb   = 0;
  localparam int gpio_addr_width = 16;

  localparam logic [gpio_addr_width-1:0] run_trig_reg = 16'h0000;
  localparam logic [gpio_addr_width-1:0] del_trig_reg = 16'h0001;

  localparam int gpio_sync_stages    = 2;
  localparam int cfg_fifo_depth_log2 = 2;

  typedef struct packed {
    logic [gpio_addr_width-1:0] addr;
    logic [gpio_data_width-1:0] data;
  } cfg_wr_t;

endpackage

// File: rtl/gpio_cfg_decoder_fifo.sv
// Write queue between the GPIO strobe detector and the config bus. A push into
// a full queue is accepted when the head pops in the same cycle.
module cfg_wr_fifo
  import gpio_cfg_decoder_pkg::*;
#(
  parameter int DEPTH_LOG2 = cfg_fifo_depth_log2
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push_i,
  input  cfg_wr_t wr_i,
  input  logic    pop_i,
  output cfg_wr_t rd_o,
  output logic    full_o,
  output logic    empty_o
);

  localparam int DEPTH = 2**DEPTH_LOG2;

  cfg_wr_t               mem_q [DEPTH];
  cfg_wr_t               last_q;
  logic [DEPTH_LOG2:0]   wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2-1:0] wr_idx, rd_idx;
  logic                  do_push, do_pop;

  assign wr_idx  = wr_ptr_q[DEPTH_LOG2-1:0];
  assign rd_idx  = rd_ptr_q[DEPTH_LOG2-1:0];
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_idx == rd_idx) && (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Empty queue keeps presenting the last entry handed off.
  assign rd_o = empty_o ? last_q : mem_q[rd_idx];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_idx] <= wr_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      last_q   <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (DEPTH_LOG2+1)'(1);
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + (DEPTH_LOG2+1)'(1);
        last_q   <= mem_q[rd_idx];
      end
    end
  end

endmodule

// File: rtl/gpio_cfg_decoder.sv
// PS GPIO to config-bus bridge: synchronises the GPIO word, turns rising edges
// of the write-clock bit into queued writes and decodes the trigger registers.
module gpio_cfg_decoder
  import gpio_cfg_decoder_pkg::*;
#(
  parameter int SYNC_STAGES     = gpio_sync_stages,
  parameter int FIFO_DEPTH_LOG2 = cfg_fifo_depth_log2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [gpio_word_width-1:0] gpio_in,
  output logic                       cfg_valid,
  input  logic                       cfg_ready,
  output logic [gpio_addr_width-1:0] cfg_addr,
  output logic [gpio_data_width-1:0] cfg_data,
  output logic                       run_trig,
  output logic                       del_trig,
  output logic                       overflow,
  output logic [15:0]                wr_count
);

  logic [gpio_word_width-1:0] sync_q [SYNC_STAGES];
  logic [gpio_word_width-1:0] sync_w;
  logic [SYNC_STAGES-1:0]     fill_q;
  logic                       prev_w_q, armed_q, armed_d;
  logic                       overflow_q, overflow_d;
  logic                       run_trig_q, del_trig_q;
  logic [15:0]                wr_count_q, wr_count_d;
  logic                       strobe, pop, push_acc, fifo_full, fifo_empty;
  cfg_wr_t                    wr_word, head;

  assign sync_w       = sync_q[SYNC_STAGES-1];
  assign strobe       = armed_q & sync_w[gpio_wclk_bit] & ~prev_w_q;
  assign wr_word.addr = sync_w[gpio_addr_lsb +: gpio_addr_width];
  assign wr_word.data = sync_w[gpio_data_lsb +: gpio_data_width];
  assign pop          = ~fifo_empty & cfg_ready;
  assign push_acc     = strobe & (~fifo_full | pop);

  // fill_q marks when the last sync stage holds a real post-reset sample, so
  // the reset-value zeros cannot arm the edge detector.
  always_comb begin
    armed_d    = armed_q | (fill_q[SYNC_STAGES-1] & ~sync_w[gpio_wclk_bit]);
    wr_count_d = wr_count_q + 16'(push_acc);
    overflow_d = overflow_q | (strobe & ~push_acc);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      fill_q     <= '0;
      prev_w_q   <= 1'b0;
      armed_q    <= 1'b0;
      overflow_q <= 1'b0;
      wr_count_q <= '0;
      run_trig_q <= 1'b0;
      del_trig_q <= 1'b0;
    end else begin
      sync_q[0] <= gpio_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      fill_q     <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      prev_w_q   <= sync_w[gpio_wclk_bit];
      armed_q    <= armed_d;
      overflow_q <= overflow_d;
      wr_count_q <= wr_count_d;
      run_trig_q <= pop & (head.addr == run_trig_reg);
      del_trig_q <= pop & (head.addr == del_trig_reg);
    end
  end

  cfg_wr_fifo #(.DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (strobe),
    .wr_i    (wr_word),
    .pop_i   (pop),
    .rd_o    (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign cfg_valid = ~fifo_empty;
  assign cfg_addr  = head.addr;
  assign cfg_data  = head.data;
  assign run_trig  = run_trig_q;
  assign del_trig  = del_trig_q;
  assign overflow  = overflow_q;
  assign wr_count  = wr_count_q;

endmodule

// File: tb/tb_gpio_cfg_decoder.sv
// Bench for gpio_cfg_decoder: directed scenarios plus random writes, checked
// every cycle against a queue model of GPIO write events and handoffs.
module tb_gpio_cfg_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [24:0] gpio_in = '0;
  logic        cfg_ready = 1'b0;
  logic        cfg_valid, run_trig, del_trig, overflow;
  logic [15:0] cfg_addr, wr_count;
  logic [7:0]  cfg_data;

  always #5 clk = ~clk;

  gpio_cfg_decoder dut (
    .clk       (clk),
    .rst       (rst),
    .gpio_in   (gpio_in),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .run_trig  (run_trig),
    .del_trig  (del_trig),
    .overflow  (overflow),
    .wr_count  (wr_count)
  );

  typedef struct {
    int          due;
    logic [23:0] wr;
  } pend_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          dut_hand = 0;
  pend_t       pend[$];
  logic [23:0] mq[$];
  logic [23:0] handed[$];
  logic [23:0] last_wr;
  bit          prev_valid, prev_b, exp_ovf, exp_run, exp_del;
  int          exp_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    pend.delete();
    mq.delete();
    last_wr    = '0;
    prev_valid = 0;
    prev_b     = 0;
    exp_cnt    = 0;
    exp_ovf    = 0;
    exp_run    = 0;
    exp_del    = 0;
  endtask

  task automatic check_outputs();
    logic [23:0] head;
    head = (mq.size() != 0) ? mq[0] : last_wr;
    chk("cfg_valid", cfg_valid, mq.size() != 0);
    chk("cfg_addr", cfg_addr, head[23:8]);
    chk("cfg_data", cfg_data, head[7:0]);
    chk("run_trig", run_trig, exp_run);
    chk("del_trig", del_trig, exp_del);
    chk("overflow", overflow, exp_ovf);
    chk("wr_count", wr_count, 32'(exp_cnt % 65536));
  endtask

  // One clock: the model applies the rules for the edge using the inputs the
  // DUT sampled, then all outputs are compared just after the edge.
  task automatic step();
    logic [24:0] w;
    logic [23:0] e;
    pend_t       p;
    bit          rdy;
    w   = gpio_in;
    rdy = cfg_ready;
    if (cfg_valid && cfg_ready) dut_hand++;
    @(posedge clk);
    #1;
    if (prev_valid && !prev_b && w[24]) pend.push_back('{cyc + 2, {w[15:0], w[23:16]}});
    prev_valid = 1;
    prev_b     = w[24];
    exp_run    = 0;
    exp_del    = 0;
    if (mq.size() != 0 && rdy) begin
      e       = mq.pop_front();
      last_wr = e;
      handed.push_back(e);
      exp_run = (e[23:8] == 16'h0000);
      exp_del = (e[23:8] == 16'h0001);
    end
    if (pend.size() != 0 && pend[0].due == cyc) begin
      p = pend.pop_front();
      if (mq.size() < 4) begin
        mq.push_back(p.wr);
        exp_cnt++;
      end else begin
        exp_ovf = 1;
      end
    end
    cyc++;
    check_outputs();
  endtask

  task automatic gpio_write(input logic [15:0] a, input logic [7:0] d, input int hi, input int lo);
    gpio_in = {1'b0, d, a};
    step();
    gpio_in[24] = 1'b1;
    repeat (hi) step();
    gpio_in[24] = 1'b0;
    repeat (lo) step();
  endtask

  // Called just after an edge; asserts reset mid-cycle and checks the
  // asynchronous clear before any further clock edge.
  task automatic do_reset();
    #4;
    rst = 1'b0;
    #1;
    chk("rst_async_valid", cfg_valid, 0);
    chk("rst_async_count", wr_count, 0);
    chk("rst_async_ovf", overflow, 0);
    chk("rst_async_addr", cfg_addr, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    model_clear();
  endtask

  initial begin
    logic [15:0] ra;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", cfg_valid, 0);
    chk("reset_addr", cfg_addr, 0);
    chk("reset_data", cfg_data, 0);
    chk("reset_run", run_trig, 0);
    chk("reset_del", del_trig, 0);
    chk("reset_ovf", overflow, 0);
    chk("reset_count", wr_count, 0);
    rst = 1'b1;
    model_clear();
    cfg_ready = 1'b1;
    repeat (3) step();

    // single write with latency check
    dut_hand = 0;
    gpio_in = {1'b0, 8'h5A, 16'h0123};
    step();
    gpio_in[24] = 1'b1;
    step();
    chk("lat_n", cfg_valid, 0);
    step();
    chk("lat_n1", cfg_valid, 0);
    step();
    chk("lat_n2_valid", cfg_valid, 1);
    chk("lat_n2_addr", cfg_addr, 16'h0123);
    chk("lat_n2_data", cfg_data, 8'h5A);
    repeat (7) step();
    gpio_in[24] = 1'b0;
    repeat (4) step();
    chk("single_count", wr_count, 1);
    chk("single_hand", dut_hand, 1);

    // trigger ordering
    handed.delete();
    gpio_write(16'h0100, 8'h11, 2, 3);
    gpio_write(16'h0000, 8'h01, 2, 3);
    gpio_write(16'h0001, 8'h00, 2, 3);
    repeat (4) step();
    chk("trig_nhand", handed.size(), 3);
    chk("trig_h0", handed[0], 24'h010011);
    chk("trig_h1", handed[1], 24'h000001);
    chk("trig_h2", handed[2], 24'h000100);
    chk("trig_count", wr_count, 4);

    // backpressure and overflow
    do_reset();
    cfg_ready = 1'b0;
    repeat (3) step();
    handed.delete();
    for (int i = 0; i < 6; i++) gpio_write(16'h0200 + 16'(i), 8'hA0 + 8'(i), 2, 2);
    repeat (2) step();
    chk("bp_valid", cfg_valid, 1);
    chk("bp_head", cfg_addr, 16'h0200);
    chk("bp_count", wr_count, 4);
    chk("bp_ovf", overflow, 1);
    cfg_ready = 1'b1;
    repeat (6) step();
    chk("bp_nhand", handed.size(), 4);
    for (int i = 0; i < 4; i++) chk("bp_order", handed[i], {16'h0200 + 16'(i), 8'hA0 + 8'(i)});
    chk("bp_drained", cfg_valid, 0);

    // full queue, push and pop on the same edge
    do_reset();
    cfg_ready = 1'b0;
    repeat (3) step();
    for (int i = 0; i < 4; i++) gpio_write(16'h0300 + 16'(i), 8'hB0 + 8'(i), 2, 2);
    repeat (2) step();
    gpio_in = {1'b0, 8'hC5, 16'h0305};
    step();
    gpio_in[24] = 1'b1;
    step();
    step();
    cfg_ready = 1'b1;
    step();
    cfg_ready = 1'b0;
    chk("fp_ovf", overflow, 0);
    chk("fp_count", wr_count, 5);
    chk("fp_head", cfg_addr, 16'h0301);
    gpio_in[24] = 1'b0;
    repeat (2) step();
    handed.delete();
    cfg_ready = 1'b1;
    repeat (6) step();
    chk("fp_nhand", handed.size(), 4);
    chk("fp_first", handed[0], 24'h0301B1);
    chk("fp_last", handed[3], 24'h0305C5);

    // strobe held high across reset release
    cfg_ready = 1'b0;
    gpio_in = {1'b1, 8'h77, 16'h0400};
    do_reset();
    repeat (6) step();
    chk("held_count", wr_count, 0);
    chk("held_valid", cfg_valid, 0);
    gpio_in[24] = 1'b0;
    repeat (3) step();
    gpio_in[24] = 1'b1;
    repeat (4) step();
    gpio_in[24] = 1'b0;
    repeat (2) step();
    chk("rearm_count", wr_count, 1);
    chk("rearm_addr", cfg_addr, 16'h0400);

    // reset with entries queued
    do_reset();
    repeat (3) step();
    gpio_write(16'h0500, 8'h50, 2, 2);
    gpio_write(16'h0501, 8'h51, 2, 2);
    chk("mid_valid_pre", cfg_valid, 1);
    chk("mid_count_pre", wr_count, 2);
    do_reset();
    repeat (3) step();
    cfg_ready = 1'b1;
    repeat (4) step();
    chk("mid_valid_post", cfg_valid, 0);
    chk("mid_count_post", wr_count, 0);

    // random writes, random backpressure
    do_reset();
    repeat (3) step();
    for (int n = 0; n < 80; n++) begin
      ra = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 1)) : 16'($urandom);
      cfg_ready = ($urandom_range(0, 3) != 0);
      gpio_write(ra, 8'($urandom), $urandom_range(1, 4), $urandom_range(1, 4));
    end
    cfg_ready = 1'b1;
    repeat (10) step();
    chk("rand_drained", cfg_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
